// File: rtl/led_axil_regs.sv
// AXI4-Lite slave: four 32-bit regs, B one cycle after AW+W held, R registered one cycle after AR; one write and one read in flight,
// readies drop while a response waits for B/RREADY. LED = REG0[3:0], optionally blinked by REG2 mask with period REG1 (LEDHW_BLINK_EN).
module led_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [3:0]                        LED
);

  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
  logic                          rdy_en;
  logic                          aw_held;
  logic                          w_held;
  logic [1:0]                    aw_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_dat;
  logic [STRB_W-1:0]             w_strb;
  logic                          bvalid;
  logic                          rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata;
  logic [3:0]                    led_q;
  logic [3:0]                    led_next;
  logic                          aw_hs;
  logic                          w_hs;
  logic                          ar_hs;
  logic                          commit;
  logic                          unused_ok;

  // rdy_en keeps every ready low while reset is held and for the reset cycle itself
  assign S_AXI_AWREADY = rdy_en & ~aw_held & ~bvalid;
  assign S_AXI_WREADY  = rdy_en & ~w_held & ~bvalid;
  assign S_AXI_ARREADY = rdy_en & ~rvalid;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = 2'b00;
  assign LED           = led_q;

  assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
  assign commit = aw_held & w_held & ~bvalid;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (commit) begin
      for (int b = 0; b < STRB_W; b++)
        if (w_strb[b]) regs[aw_idx][8*b +: 8] <= w_dat[8*b +: 8];
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      rdy_en  <= 1'b0;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_idx  <= '0;
      w_dat   <= '0;
      w_strb  <= '0;
      bvalid  <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      led_q   <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[3:2];
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_dat  <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (commit) bvalid <= 1'b1;
      // readies are low while bvalid is set, so clearing here cannot race a new handshake
      if (bvalid && S_AXI_BREADY) begin
        bvalid  <= 1'b0;
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
      // regs[] read here is the pre-commit value when a write lands on the same edge
      if (ar_hs) begin
        rvalid <= 1'b1;
        rdata  <= regs[S_AXI_ARADDR[3:2]];
      end else if (rvalid && S_AXI_RREADY) begin
        rvalid <= 1'b0;
      end
      led_q <= led_next;
    end
  end

`ifdef LEDHW_BLINK_EN
  logic [31:0] blink_cnt;
  logic        phase;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (commit && aw_idx == 2'd1) begin
      blink_cnt <= '0;
    end else if (regs[1] == '0) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == regs[1]) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 32'd1;
    end
  end

  assign led_next = regs[0][3:0] ^ ({4{phase}} & regs[2][3:0]);
`else
  assign led_next = regs[0][3:0];
`endif

endmodule

// File: tb/tb_led_axil_regs.sv
// Directed bench for led_axil_regs: handshake timing, strobes, backpressure, reset abandonment, optional blink.
module tb_led_axil_regs;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [3:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [3:0]  led;

  int vectors = 0;
  int miscompares = 0;

  always #5 aclk = ~aclk;

  led_axil_regs dut (
    .S_AXI_ACLK(aclk), .S_AXI_ARESET(areset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .LED(led)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output bit ok);
    bit aw_done, w_done, aw_f, w_f;
    int n;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      tick(); n++;
      if (aw_f) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_f)  begin wvalid = 1'b0;  w_done = 1'b1;  end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1; n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    ok = aw_done && w_done && bvalid;
    resp = bresp;
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp,
                          output bit ok);
    bit ar_f;
    int n;
    araddr = addr; arvalid = 1'b1; n = 0; ar_f = 1'b0;
    while (!ar_f && n < 20) begin
      ar_f = arready;
      tick(); n++;
    end
    arvalid = 1'b0;
    rready = 1'b1; n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    ok = ar_f && rvalid;
    data = rdata; resp = rresp;
    tick();
    rready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    vectors++; if ({awready, wready, arready} !== 3'b000) begin miscompares++; $display("FAIL reset_readies: got %b want 000", {awready, wready, arready}); end
    vectors++; if ({bvalid, rvalid} !== 2'b00) begin miscompares++; $display("FAIL reset_valids: got %b want 00", {bvalid, rvalid}); end
    vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    vectors++; if (led !== 4'h0) begin miscompares++; $display("FAIL reset_led: got %h want 0", led); end
    areset = 1'b0;
    tick();
    vectors++; if ({awready, wready, arready} !== 3'b111) begin miscompares++; $display("FAIL post_reset_readies: got %b want 111", {awready, wready, arready}); end
  endtask

  task automatic test_basic();
    logic [1:0] resp; logic [31:0] d; bit ok; logic [3:0] a;
    for (int i = 0; i < 4; i++) begin
      a = 4'(i * 4);
      axi_write(a, 32'(i + 1), 4'hF, resp, ok);
      vectors++; if (!ok || resp !== 2'b00) begin miscompares++; $display("FAIL basic_write[%0d]: ok=%0d bresp=%b want ok=1 bresp=00", i, ok, resp); end
    end
    for (int i = 0; i < 4; i++) begin
      a = 4'(i * 4);
      axi_read(a, d, resp, ok);
      vectors++; if (!ok || d !== 32'(i + 1) || resp !== 2'b00) begin miscompares++; $display("FAIL basic_read[%0d]: ok=%0d data=%h rresp=%b want data=%h rresp=00", i, ok, d, resp, 32'(i + 1)); end
    end
`ifndef LEDHW_BLINK_EN
    vectors++; if (led !== 4'h1) begin miscompares++; $display("FAIL basic_led: got %h want 1", led); end
`endif
  endtask

  task automatic test_split_order();
    logic [1:0] resp; logic [31:0] d; bit ok; bit aw_first; logic [3:0] a; logic [31:0] v;
    for (int k = 0; k < 2; k++) begin
      aw_first = (k == 0);
      a = aw_first ? 4'h8 : 4'hC;
      v = aw_first ? 32'h0000_00A5 : 32'h0000_005A;
      awaddr = a; wdata = v; wstrb = 4'hF;
      if (aw_first) awvalid = 1'b1; else wvalid = 1'b1;
      vectors++; if ((aw_first ? awready : wready) !== 1'b1) begin miscompares++; $display("FAIL split%0d_early_ready: got 0 want 1", k); end
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      repeat (3) begin
        vectors++; if (bvalid !== 1'b0) begin miscompares++; $display("FAIL split%0d_bvalid_early: got 1 want 0", k); end
        tick();
      end
      if (aw_first) wvalid = 1'b1; else awvalid = 1'b1;
      vectors++; if ((aw_first ? wready : awready) !== 1'b1) begin miscompares++; $display("FAIL split%0d_late_ready: got 0 want 1", k); end
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      vectors++; if (bvalid !== 1'b0) begin miscompares++; $display("FAIL split%0d_bvalid_at_hs: got 1 want 0", k); end
      tick();
      vectors++; if (bvalid !== 1'b1) begin miscompares++; $display("FAIL split%0d_bvalid_latency: got 0 want 1", k); end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      tick();
      vectors++; if (bvalid !== 1'b0) begin miscompares++; $display("FAIL split%0d_single_commit: bvalid got 1 want 0", k); end
      axi_read(a, d, resp, ok);
      vectors++; if (!ok || d !== v) begin miscompares++; $display("FAIL split%0d_readback: got %h want %h", k, d, v); end
    end
  endtask

  task automatic test_concurrent_rw();
    logic [1:0] resp; logic [31:0] d; bit ok;
    awaddr = 4'h0; wdata = 32'h7; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    vectors++; if (bvalid !== 1'b0) begin miscompares++; $display("FAIL same_cycle_bvalid_at_hs: got 1 want 0"); end
    araddr = 4'h0; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    vectors++; if ({bvalid, rvalid} !== 2'b11) begin miscompares++; $display("FAIL same_cycle_b_and_r: got %b want 11", {bvalid, rvalid}); end
    vectors++; if (rdata !== 32'h1) begin miscompares++; $display("FAIL read_during_write: got %h want 00000001", rdata); end
`ifndef LEDHW_BLINK_EN
    vectors++; if (led !== 4'h1) begin miscompares++; $display("FAIL led_at_commit: got %h want 1", led); end
`endif
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
`ifndef LEDHW_BLINK_EN
    vectors++; if (led !== 4'h7) begin miscompares++; $display("FAIL led_after_commit: got %h want 7", led); end
`endif
    axi_read(4'h0, d, resp, ok);
    vectors++; if (!ok || d !== 32'h7) begin miscompares++; $display("FAIL reg0_after_concurrent: got %h want 00000007", d); end
  endtask

  task automatic test_strobe();
    logic [1:0] resp; logic [31:0] d; bit ok;
    axi_write(4'hC, 32'hFFFF_FFFF, 4'hF, resp, ok);
    axi_write(4'hC, 32'h1234_5678, 4'b0101, resp, ok);
    axi_read(4'hC, d, resp, ok);
    vectors++; if (!ok || d !== 32'hFF34_FF78) begin miscompares++; $display("FAIL strobe_merge: got %h want ff34ff78", d); end
  endtask

  task automatic test_backpressure();
    awaddr = 4'h4; wdata = 32'h11; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    repeat (5) begin
      vectors++; if ({bvalid, awready, wready} !== 3'b100) begin miscompares++; $display("FAIL b_hold: got %b want 100", {bvalid, awready, wready}); end
      tick();
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    vectors++; if ({bvalid, awready, wready} !== 3'b011) begin miscompares++; $display("FAIL b_release: got %b want 011", {bvalid, awready, wready}); end
    araddr = 4'h4; arvalid = 1'b1;
    tick();
    araddr = 4'h0;
    repeat (5) begin
      vectors++; if ({rvalid, arready} !== 2'b10 || rdata !== 32'h11) begin miscompares++; $display("FAIL r_hold: rvalid,arready=%b rdata=%h want 10 00000011", {rvalid, arready}, rdata); end
      tick();
    end
    rready = 1'b1;
    tick();
    vectors++; if ({rvalid, arready} !== 2'b01) begin miscompares++; $display("FAIL r_release: got %b want 01", {rvalid, arready}); end
    tick();
    arvalid = 1'b0;
    vectors++; if (rvalid !== 1'b1 || rdata !== 32'h7) begin miscompares++; $display("FAIL back_to_back_ar: rvalid=%b rdata=%h want 1 00000007", rvalid, rdata); end
    tick();
    rready = 1'b0;
    vectors++; if (rvalid !== 1'b0) begin miscompares++; $display("FAIL back_to_back_r_done: got 1 want 0"); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp; logic [31:0] d; bit ok;
    awaddr = 4'h0; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    areset = 1'b1;
    wdata = 32'hDEAD; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    vectors++; if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || rdata !== 32'h0 || led !== 4'h0) begin miscompares++; $display("FAIL mid_reset_outputs: ctl=%b rdata=%h led=%h want 0", {awready, wready, arready, bvalid, rvalid}, rdata, led); end
    tick();
    areset = 1'b0; wvalid = 1'b0;
    tick();
    vectors++; if ({awready, wready, bvalid} !== 3'b110) begin miscompares++; $display("FAIL mid_reset_recover: got %b want 110", {awready, wready, bvalid}); end
    axi_write(4'h8, 32'h99, 4'hF, resp, ok);
    vectors++; if (!ok || resp !== 2'b00) begin miscompares++; $display("FAIL mid_reset_write: ok=%0d bresp=%b want 1 00", ok, resp); end
    axi_read(4'h8, d, resp, ok);
    vectors++; if (!ok || d !== 32'h99) begin miscompares++; $display("FAIL mid_reset_readback: got %h want 00000099", d); end
    axi_read(4'h0, d, resp, ok);
    vectors++; if (!ok || d !== 32'h0) begin miscompares++; $display("FAIL mid_reset_reg0: got %h want 0", d); end
  endtask

`ifdef LEDHW_BLINK_EN
  task automatic test_blink();
    logic [1:0] resp; bit ok; logic [3:0] prev; int n;
    axi_write(4'h0, 32'h0, 4'hF, resp, ok);
    axi_write(4'h8, 32'hF, 4'hF, resp, ok);
    axi_write(4'h4, 32'h4, 4'hF, resp, ok);
    prev = led; n = 0;
    while (led === prev && n < 20) begin tick(); n++; end
    vectors++; if (n >= 20) begin miscompares++; $display("FAIL blink_start: no toggle within 20 cycles"); end
    for (int k = 0; k < 2; k++) begin
      prev = led; n = 0;
      do begin tick(); n++; end while (led === prev && n < 20);
      vectors++; if (n !== 5 || led !== (prev ^ 4'hF)) begin miscompares++; $display("FAIL blink_period[%0d]: cycles=%0d led=%h want 5 %h", k, n, led, prev ^ 4'hF); end
    end
    axi_write(4'h4, 32'h0, 4'hF, resp, ok);
    repeat (3) tick();
    repeat (6) begin
      vectors++; if (led !== 4'h0) begin miscompares++; $display("FAIL blink_off: got %h want 0", led); end
      tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_split_order();
    test_concurrent_rw();
    test_strobe();
    test_backpressure();
    test_reset_mid();
`ifdef LEDHW_BLINK_EN
    test_blink();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
